deadtime_monitor: RTL and testbench
===================================

Name: deadtime_monitor

Overview:
- Receive-side checker for a complementary gate pair produced by the dead-time generator. It samples gate_a and gate_b.
- Reconstructs the original PWM command and measures the dead time on every A-to-B and B-to-A handover.
- Flags shoot-through (both gates high) and insufficient dead time (below a programmable minimum).
- Sits on the gate-output side of the PWM chain for on-chip self-test and fault capture.

Parameters:
- CNT_W, 8: width of the dead-time counter, the min_dtime input and the measurement outputs.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- gate_a  input  1  high-side gate signal under observation.
- gate_b  input  1  low-side gate signal under observation.
- min_dtime  input  CNT_W  minimum legal dead time, in clk cycles.
- clr_fault  input  1  synchronous clear of both sticky fault flags.
- pwm_rec  output  1  reconstructed PWM: 1 while A conducts, 0 while B conducts.
- dt_ab  output  CNT_W  last measured dead time from A falling to B rising.
- dt_ba  output  CNT_W  last measured dead time from B falling to A rising.
- dt_valid  output  1  one-cycle pulse when dt_ab or dt_ba is updated.
- dt_dir  output  1  direction of the latest measurement: 0 = A to B, 1 = B to A.
- fault_short  output  1  sticky: a measured dead time was below min_dtime.
- fault_overlap  output  1  sticky: gate_a and gate_b were both high in the same sample.

Behaviour:
- Reset: one clock (clk); reset is asynchronous and active-low (reset_n). While reset_n = 0:
  - FSM goes to OFF_INIT.
  - All outputs are 0, the counter is 0, the input sample registers are 0.
- Input path: gate_a/gate_b are registered once into a_q/b_q. The FSM and all outputs are registered and act on a_q/b_q.
- Latency: 2 clk from a gate pin change to the corresponding output change.
- FSM states: OFF_INIT, A_ON, B_ON, DT_AB, DT_BA, OVERLAP.
- Overlap priority: in any state, a_q = 1 and b_q = 1 → go to OVERLAP, set fault_overlap. No measurement, counter cleared.
- OFF_INIT:
  - a_q only → A_ON.
  - b_q only → B_ON.
  - Both low → stay.
  - No measurement, because the direction is unknown.
- A_ON:
  - Both low → DT_AB, counter = 1.
  - b_q only (zero dead time) → B_ON with dt_ab = 0, dt_valid = 1, dt_dir = 0. Set fault_short if min_dtime > 0.
- DT_AB:
  - Both low → counter + 1, saturating at 2^CNT_W − 1.
  - b_q rises → B_ON with dt_ab = counter, dt_valid = 1, dt_dir = 0. Set fault_short if counter < min_dtime.
  - a_q rises (aborted handover) → A_ON, no dt_valid, counter cleared.
- B_ON and DT_BA: mirror images of A_ON and DT_AB. They update dt_ba with dt_dir = 1.
- OVERLAP, once the gates are no longer both high:
  - a only → A_ON.
  - b only → B_ON.
  - Both low → OFF_INIT.
- pwm_rec:
  - 1 on entering A_ON, 0 on entering B_ON.
  - Holds its value in OFF_INIT, DT_AB, DT_BA and OVERLAP.
- Dead-time definition: dead time = number of samples with both gates low between the two edges.
- Comparison: min_dtime is compared unsigned. min_dtime = 0 disables fault_short.
- dt_ab/dt_ba hold their value until the next valid measurement in the same direction.
- Sticky faults: clr_fault clears both fault flags. If a fault event occurs in the same cycle as clr_fault, the set wins.
- Reset mid-handover: the measurement is discarded and no dt_valid is produced.

Optional Feature:
- Macro: DEADTIME_MONITOR_SYNC_EN.
- Defined:
  - gate_a/gate_b pass through a 2-flop synchronizer (reset to 0) before the a_q/b_q sample stage.
  - This supports asynchronous pin-level inputs.
  - Pin-to-output latency becomes 4 clk. Measured dead-time values are unchanged.
- Undefined: the inputs are assumed synchronous to clk, and latency is 2 clk.

Test Plan:
1. Hold reset_n = 0 with gate_a = 1 → all outputs 0. Release, then apply gate_a = 1 → pwm_rec = 1 two cycles later and dt_valid stays 0.
2. min_dtime = 3: gate_a high 10 cycles, both low 5 cycles, gate_b high → one dt_valid pulse with dt_dir = 0, dt_ab = 5, pwm_rec 1→0, fault_short = 0.
3. min_dtime = 8, same waveform → dt_ab = 5 and fault_short = 1, still set 20 cycles later. Pulse clr_fault → 0. Repeat with clr_fault coincident with the B rising edge → fault_short stays 1.
4. gate_a and gate_b both high for 1 cycle, then only gate_b → fault_overlap = 1, no dt_valid, pwm_rec = 0 after entering B_ON.
5. CNT_W = 8, both gates low for 300 cycles after B_ON, then gate_a high → dt_ba = 255, dt_dir = 1.
6. Aborted handover: gate_a high, both low 3 cycles, gate_a high again → no dt_valid, pwm_rec stays 1. Assert reset_n low during a DT_AB interval → no dt_valid after release, all outputs 0.

Source files
------------

// File: rtl/deadtime_monitor.sv
// Receive-side checker for a complementary gate pair: rebuilds the PWM command,
// measures dead time per handover, and flags short dead time and gate overlap.
// Optional DEADTIME_MONITOR_SYNC_EN adds a 2-flop input synchronizer.
module deadtime_monitor #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             gate_a,
  input  logic             gate_b,
  input  logic [CNT_W-1:0] min_dtime,
  input  logic             clr_fault,
  output logic             pwm_rec,
  output logic [CNT_W-1:0] dt_ab,
  output logic [CNT_W-1:0] dt_ba,
  output logic             dt_valid,
  output logic             dt_dir,
  output logic             fault_short,
  output logic             fault_overlap
);

  typedef enum logic [2:0] {
    OFF_INIT, A_ON, B_ON, DT_AB, DT_BA, OVERLAP
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  logic a_in, b_in;

`ifdef DEADTIME_MONITOR_SYNC_EN
  logic [1:0] a_sync_q, a_sync_d, b_sync_q, b_sync_d;

  always_comb begin
    a_sync_d = {a_sync_q[0], gate_a};
    b_sync_d = {b_sync_q[0], gate_b};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_sync_q <= '0;
      b_sync_q <= '0;
    end else begin
      a_sync_q <= a_sync_d;
      b_sync_q <= b_sync_d;
    end
  end

  assign a_in = a_sync_q[1];
  assign b_in = b_sync_q[1];
`else
  assign a_in = gate_a;
  assign b_in = gate_b;
`endif

  logic             a_q, a_d, b_q, b_d;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pwm_q, pwm_d;
  logic [CNT_W-1:0] dt_ab_q, dt_ab_d, dt_ba_q, dt_ba_d;
  logic             dt_valid_q, dt_valid_d;
  logic             dt_dir_q, dt_dir_d;
  logic             fault_short_q, fault_short_d;
  logic             fault_overlap_q, fault_overlap_d;
  logic             short_set, overlap_set;

  // Sample stage: everything downstream acts on a_q/b_q only
  always_comb begin
    a_d = a_in;
    b_d = b_in;
  end

  // Decision stage: FSM, measurement and sticky faults
  always_comb begin
    state_d     = state_q;
    cnt_d       = '0;
    pwm_d       = pwm_q;
    dt_ab_d     = dt_ab_q;
    dt_ba_d     = dt_ba_q;
    dt_valid_d  = 1'b0;
    dt_dir_d    = dt_dir_q;
    short_set   = 1'b0;
    overlap_set = 1'b0;

    if (a_q && b_q) begin
      state_d     = OVERLAP;
      overlap_set = 1'b1;
    end else begin
      case (state_q)
        OFF_INIT, OVERLAP: begin
          if (a_q) begin
            state_d = A_ON;
            pwm_d   = 1'b1;
          end else if (b_q) begin
            state_d = B_ON;
            pwm_d   = 1'b0;
          end else begin
            state_d = OFF_INIT;
          end
        end
        A_ON: begin
          if (!a_q && !b_q) begin
            state_d = DT_AB;
            cnt_d   = 1;
          end else if (b_q) begin
            state_d    = B_ON;
            pwm_d      = 1'b0;
            dt_ab_d    = '0;
            dt_valid_d = 1'b1;
            dt_dir_d   = 1'b0;
            short_set  = (min_dtime != '0);
          end
        end
        B_ON: begin
          if (!a_q && !b_q) begin
            state_d = DT_BA;
            cnt_d   = 1;
          end else if (a_q) begin
            state_d    = A_ON;
            pwm_d      = 1'b1;
            dt_ba_d    = '0;
            dt_valid_d = 1'b1;
            dt_dir_d   = 1'b1;
            short_set  = (min_dtime != '0);
          end
        end
        DT_AB: begin
          if (b_q) begin
            state_d    = B_ON;
            pwm_d      = 1'b0;
            dt_ab_d    = cnt_q;
            dt_valid_d = 1'b1;
            dt_dir_d   = 1'b0;
            short_set  = (cnt_q < min_dtime);
          end else if (a_q) begin
            state_d = A_ON;
            pwm_d   = 1'b1;
          end else begin
            cnt_d = sat_inc(cnt_q);
          end
        end
        DT_BA: begin
          if (a_q) begin
            state_d    = A_ON;
            pwm_d      = 1'b1;
            dt_ba_d    = cnt_q;
            dt_valid_d = 1'b1;
            dt_dir_d   = 1'b1;
            short_set  = (cnt_q < min_dtime);
          end else if (b_q) begin
            state_d = B_ON;
            pwm_d   = 1'b0;
          end else begin
            cnt_d = sat_inc(cnt_q);
          end
        end
        default: state_d = OFF_INIT;
      endcase
    end

    // A new fault event in the clearing cycle takes precedence over the clear
    fault_short_d   = short_set   | (fault_short_q   & ~clr_fault);
    fault_overlap_d = overlap_set | (fault_overlap_q & ~clr_fault);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_q             <= 1'b0;
      b_q             <= 1'b0;
      state_q         <= OFF_INIT;
      cnt_q           <= '0;
      pwm_q           <= 1'b0;
      dt_ab_q         <= '0;
      dt_ba_q         <= '0;
      dt_valid_q      <= 1'b0;
      dt_dir_q        <= 1'b0;
      fault_short_q   <= 1'b0;
      fault_overlap_q <= 1'b0;
    end else begin
      a_q             <= a_d;
      b_q             <= b_d;
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      pwm_q           <= pwm_d;
      dt_ab_q         <= dt_ab_d;
      dt_ba_q         <= dt_ba_d;
      dt_valid_q      <= dt_valid_d;
      dt_dir_q        <= dt_dir_d;
      fault_short_q   <= fault_short_d;
      fault_overlap_q <= fault_overlap_d;
    end
  end

  assign pwm_rec       = pwm_q;
  assign dt_ab         = dt_ab_q;
  assign dt_ba         = dt_ba_q;
  assign dt_valid      = dt_valid_q;
  assign dt_dir        = dt_dir_q;
  assign fault_short   = fault_short_q;
  assign fault_overlap = fault_overlap_q;

endmodule

// File: tb/tb_deadtime_monitor.sv
// Directed bench for deadtime_monitor: reset, measurement, short/overlap
// faults, counter saturation, aborted handover and reset mid-handover.
module tb_deadtime_monitor;

  localparam int CNT_W = 8;
`ifdef DEADTIME_MONITOR_SYNC_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 2;
`endif

  logic             clk = 1'b0;
  logic             reset_n;
  logic             gate_a, gate_b;
  logic [CNT_W-1:0] min_dtime;
  logic             clr_fault;
  logic             pwm_rec;
  logic [CNT_W-1:0] dt_ab, dt_ba;
  logic             dt_valid, dt_dir;
  logic             fault_short, fault_overlap;

  int checks = 0;
  int errors = 0;
  int vld_cnt = 0;
  int v0;

  deadtime_monitor #(.CNT_W(CNT_W)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .gate_a       (gate_a),
    .gate_b       (gate_b),
    .min_dtime    (min_dtime),
    .clr_fault    (clr_fault),
    .pwm_rec      (pwm_rec),
    .dt_ab        (dt_ab),
    .dt_ba        (dt_ba),
    .dt_valid     (dt_valid),
    .dt_dir       (dt_dir),
    .fault_short  (fault_short),
    .fault_overlap(fault_overlap)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (dt_valid === 1'b1) vld_cnt++;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_pwm"}, 32'(pwm_rec), 32'd0);
    chk({tag, "_dt_ab"}, 32'(dt_ab), 32'd0);
    chk({tag, "_dt_ba"}, 32'(dt_ba), 32'd0);
    chk({tag, "_valid"}, 32'(dt_valid), 32'd0);
    chk({tag, "_dir"}, 32'(dt_dir), 32'd0);
    chk({tag, "_fshort"}, 32'(fault_short), 32'd0);
    chk({tag, "_fovl"}, 32'(fault_overlap), 32'd0);
  endtask

  initial begin
    reset_n = 1'b0; gate_a = 1'b1; gate_b = 1'b0;
    min_dtime = '0; clr_fault = 1'b0;

    // 1: reset and first A edge
    tick(3);
    chk_all_zero("rst");
    reset_n = 1'b1; gate_a = 1'b0;
    tick(3);
    gate_a = 1'b1;
    tick(LAT - 1);
    chk("a_lat_early_pwm", 32'(pwm_rec), 32'd0);
    tick(1);
    chk("a_lat_pwm", 32'(pwm_rec), 32'd1);
    chk("a_no_valid", 32'(vld_cnt), 32'd0);

    // 2: A->B, 5 dead cycles, min 3
    min_dtime = 8'd3;
    tick(10);
    v0 = vld_cnt;
    gate_a = 1'b0;
    tick(5);
    gate_b = 1'b1;
    tick(LAT);
    chk("ab5_valid", 32'(dt_valid), 32'd1);
    chk("ab5_dt_ab", 32'(dt_ab), 32'd5);
    chk("ab5_dir", 32'(dt_dir), 32'd0);
    chk("ab5_pwm", 32'(pwm_rec), 32'd0);
    chk("ab5_fshort", 32'(fault_short), 32'd0);
    tick(3);
    chk("ab5_one_pulse", 32'(vld_cnt - v0), 32'd1);

    // back to A with 5 dead cycles
    gate_b = 1'b0;
    tick(5);
    gate_a = 1'b1;
    tick(LAT);
    chk("ba5_dt_ba", 32'(dt_ba), 32'd5);
    chk("ba5_dir", 32'(dt_dir), 32'd1);
    chk("ba5_pwm", 32'(pwm_rec), 32'd1);
    chk("ba5_dt_ab_hold", 32'(dt_ab), 32'd5);

    // 3: min 8 -> short fault, sticky, then cleared
    tick(10);
    min_dtime = 8'd8;
    gate_a = 1'b0;
    tick(5);
    gate_b = 1'b1;
    tick(LAT);
    chk("short_dt_ab", 32'(dt_ab), 32'd5);
    chk("short_set", 32'(fault_short), 32'd1);
    tick(20);
    chk("short_sticky", 32'(fault_short), 32'd1);
    clr_fault = 1'b1;
    tick(1);
    clr_fault = 1'b0;
    chk("short_cleared", 32'(fault_short), 32'd0);

    min_dtime = 8'd0;
    gate_b = 1'b0;
    tick(5);
    gate_a = 1'b1;
    tick(LAT);
    chk("min0_no_short", 32'(fault_short), 32'd0);
    min_dtime = 8'd8;
    tick(10);
    gate_a = 1'b0;
    tick(5);
    gate_b = 1'b1;
    tick(LAT - 1);
    clr_fault = 1'b1;
    tick(1);
    clr_fault = 1'b0;
    chk("short_set_wins", 32'(fault_short), 32'd1);
    chk("short_set_wins_dt", 32'(dt_ab), 32'd5);
    clr_fault = 1'b1;
    tick(1);
    clr_fault = 1'b0;
    chk("short_cleared2", 32'(fault_short), 32'd0);

    // 4: overlap from A_ON, then B only
    min_dtime = 8'd0;
    gate_b = 1'b0;
    tick(3);
    gate_a = 1'b1;
    tick(5);
    chk("pre_ovl_pwm", 32'(pwm_rec), 32'd1);
    v0 = vld_cnt;
    gate_b = 1'b1;
    tick(1);
    gate_a = 1'b0;
    tick(LAT - 1);
    chk("ovl_set", 32'(fault_overlap), 32'd1);
    chk("ovl_pwm_hold", 32'(pwm_rec), 32'd1);
    tick(1);
    chk("ovl_to_b_pwm", 32'(pwm_rec), 32'd0);
    tick(3);
    chk("ovl_no_valid", 32'(vld_cnt - v0), 32'd0);
    chk("ovl_sticky", 32'(fault_overlap), 32'd1);

    // 5: counter saturation on B->A
    gate_b = 1'b0;
    tick(300);
    gate_a = 1'b1;
    tick(LAT);
    chk("sat_dt_ba", 32'(dt_ba), 32'd255);
    chk("sat_dir", 32'(dt_dir), 32'd1);
    chk("sat_valid", 32'(dt_valid), 32'd1);
    chk("sat_pwm", 32'(pwm_rec), 32'd1);

    // 6: aborted handover, then reset mid-handover
    clr_fault = 1'b1;
    tick(1);
    clr_fault = 1'b0;
    chk("ovl_cleared", 32'(fault_overlap), 32'd0);
    tick(3);
    v0 = vld_cnt;
    gate_a = 1'b0;
    tick(3);
    gate_a = 1'b1;
    tick(5);
    chk("abort_no_valid", 32'(vld_cnt - v0), 32'd0);
    chk("abort_pwm", 32'(pwm_rec), 32'd1);

    v0 = vld_cnt;
    gate_a = 1'b0;
    tick(4);
    reset_n = 1'b0;
    tick(1);
    chk_all_zero("rst_mid");
    gate_b = 1'b1;
    tick(2);
    reset_n = 1'b1;
    tick(LAT + 3);
    chk_all_zero("post_rst");
    chk("post_rst_no_valid", 32'(vld_cnt - v0), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
